// File: rtl/state_pack_cit__pack_polyvec__compress_serialize.sv
// -----------------------------------------------------------------------------
// state_pack_cit__pack_polyvec__compress_serialize
//
// Purpose:
//   Ciphertext PolyVec packing, the stage after the (x<<10)+Q/2 mask-add.
//   The block takes one group of four t values and computes
//   u_i = floor(t_i / KYBER_Q) & 0x3FF (10-bit compress) using a Barrett
//   reciprocal. It packs the four 10-bit results into 5 bytes in
//   polyvec_compress order and streams them out one byte per cycle.
//   Groups are counted per PolyVec so that the final byte of the vector
//   (KYBER_K*KYBER_N*10/8 bytes) can be flagged with oLast.
//
// Ports:
//   iClk           in   1        clock, rising edge
//   iRst           in   1        synchronous active-high reset
//   iPolyCoeffs_t0 in   i_Width  t value, coefficient 4g+0
//   iPolyCoeffs_t1 in   i_Width  t value, coefficient 4g+1
//   iPolyCoeffs_t2 in   i_Width  t value, coefficient 4g+2
//   iPolyCoeffs_t3 in   i_Width  t value, coefficient 4g+3
//   iValid         in   1        group present on t0..t3
//   oReady         out  1        block can accept a group
//   oByte          out  o_Width  packed output byte (0 when not valid)
//   oByteValid     out  1        oByte valid
//   iByteReady     in   1        consumer accepts the byte
//   oLast          out  1        last byte of the PolyVec
//   oRangeErr      out  1        sticky range error
//
// Build option:
//   KYBER_COMPRESS_CHECK_EN  when defined, oRangeErr sets on acceptance of a
//                            group with any t MSB high and stays set until
//                            iRst; otherwise oRangeErr is constant 0.
// -----------------------------------------------------------------------------
module state_pack_cit__pack_polyvec__compress_serialize #(
   parameter int KYBER_N   = 256,
   parameter int KYBER_K   = 2,
   parameter int KYBER_Q   = 3329,
   parameter int BARRETT_M = 2580335,
   parameter int BARRETT_S = 33,
   parameter int i_Width   = 24,
   parameter int o_Width   = 8
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic [i_Width-1:0] iPolyCoeffs_t0,
   input  logic [i_Width-1:0] iPolyCoeffs_t1,
   input  logic [i_Width-1:0] iPolyCoeffs_t2,
   input  logic [i_Width-1:0] iPolyCoeffs_t3,
   input  logic               iValid,
   output logic               oReady,
   output logic [o_Width-1:0] oByte,
   output logic               oByteValid,
   input  logic               iByteReady,
   output logic               oLast,
   output logic               oRangeErr
);

   localparam int U_W    = 10;
   localparam int PACK_W = 4 * U_W;
   localparam int BYTES  = PACK_W / o_Width;
   localparam int M_W    = $clog2(BARRETT_M + 1);
   localparam int PROD_W = i_Width + M_W;
   localparam int QUOT_W = PROD_W - BARRETT_S;
   localparam int Q_W    = $clog2(KYBER_Q + 1);
   localparam int CHK_W  = QUOT_W + Q_W;
   localparam int GROUPS = (KYBER_K * KYBER_N) / 4;
   localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV1 = 2'd1,
      DIV2 = 2'd2,
      EMIT = 2'd3
   } state_t;

   state_t state, next_state;

   logic [i_Width-1:0] t_p0 [4];
   logic [QUOT_W-1:0]  q_p1 [4];
   logic [PACK_W-1:0]  pack_p2;

   logic [2:0]         byte_idx;
   logic [GRP_W-1:0]   grp_cnt;

   logic accept;
   logic vld_p0, vld_p1, vld_p2;
   logic byte_xfer;
   logic last_byte;
   logic last_group;

   // Barrett quotient estimate floor(t*M / 2^S).
   function automatic logic [QUOT_W-1:0] barrett_quot(input logic [i_Width-1:0] t);
      return QUOT_W'((PROD_W'(t) * PROD_W'(BARRETT_M)) >> BARRETT_S);
   endfunction

   // Compress to 10 bits. A ceiling reciprocal can only overshoot, so a single
   // conditional decrement keeps the quotient exact across the full input
   // width; inside the normal operand range it never fires.
   function automatic logic [U_W-1:0] compress10(input logic [i_Width-1:0] t,
                                                  input logic [QUOT_W-1:0]  q_est);
      logic [QUOT_W-1:0] q;
      logic [CHK_W-1:0]  back;
      q    = q_est;
      back = CHK_W'(q) * CHK_W'(KYBER_Q);
      if (back > CHK_W'(t)) q = q - QUOT_W'(1);
      return q[U_W-1:0];
   endfunction

   assign accept     = (state == IDLE) && iValid;
   assign vld_p0     = (state == DIV1);
   assign vld_p1     = (state == DIV2);
   assign vld_p2     = (state == EMIT);
   assign byte_xfer  = vld_p2 && iByteReady;
   assign last_byte  = (byte_idx == 3'(BYTES - 1));
   assign last_group = (grp_cnt == GRP_W'(GROUPS - 1));

   always_ff @(posedge iClk) begin
      if (iRst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      oReady     = 1'b0;
      oByteValid = 1'b0;
      oByte      = '0;
      oLast      = 1'b0;
      unique case (state)
         IDLE: begin
            oReady = 1'b1;
            if (iValid) next_state = DIV1;
         end
         DIV1: next_state = DIV2;
         DIV2: next_state = EMIT;
         EMIT: begin
            oByteValid = 1'b1;
            oByte      = pack_p2[o_Width-1:0];
            oLast      = last_byte && last_group;
            if (iByteReady && last_byte) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // ---- stage p0: capture the accepted group ----
   always_ff @(posedge iClk) begin
      if (accept) begin
         t_p0[0] <= iPolyCoeffs_t0;
         t_p0[1] <= iPolyCoeffs_t1;
         t_p0[2] <= iPolyCoeffs_t2;
         t_p0[3] <= iPolyCoeffs_t3;
      end
   end

   // ---- stage p1: reciprocal multiply and shift ----
   always_ff @(posedge iClk) begin
      if (vld_p0) begin
         for (int i = 0; i < 4; i++) q_p1[i] <= barrett_quot(t_p0[i]);
      end
   end

   // ---- stage p2: compress, pack {u3,u2,u1,u0}, then shift out LSB-first ----
   always_ff @(posedge iClk) begin
      if (vld_p1) begin
         pack_p2 <= {compress10(t_p0[3], q_p1[3]), compress10(t_p0[2], q_p1[2]),
                     compress10(t_p0[1], q_p1[1]), compress10(t_p0[0], q_p1[0])};
      end else if (byte_xfer) begin
         pack_p2 <= pack_p2 >> o_Width;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         byte_idx <= '0;
         grp_cnt  <= '0;
      end else if (byte_xfer) begin
         if (last_byte) begin
            byte_idx <= '0;
            grp_cnt  <= last_group ? '0 : grp_cnt + GRP_W'(1);
         end else begin
            byte_idx <= byte_idx + 3'd1;
         end
      end
   end

`ifdef KYBER_COMPRESS_CHECK_EN
   logic range_err;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         range_err <= 1'b0;
      end else if (accept && (iPolyCoeffs_t0[i_Width-1] || iPolyCoeffs_t1[i_Width-1] ||
                              iPolyCoeffs_t2[i_Width-1] || iPolyCoeffs_t3[i_Width-1])) begin
         range_err <= 1'b1;
      end
   end

   assign oRangeErr = range_err;
`else
   assign oRangeErr = 1'b0;
`endif

endmodule

// File: tb/tb_state_pack_cit__pack_polyvec__compress_serialize.sv
// -----------------------------------------------------------------------------
// Directed testbench for state_pack_cit__pack_polyvec__compress_serialize.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_state_pack_cit__pack_polyvec__compress_serialize;

   logic        iClk = 1'b0;
   logic        iRst;
   logic [23:0] iPolyCoeffs_t0, iPolyCoeffs_t1, iPolyCoeffs_t2, iPolyCoeffs_t3;
   logic        iValid;
   logic        oReady;
   logic [7:0]  oByte;
   logic        oByteValid;
   logic        iByteReady;
   logic        oLast;
   logic        oRangeErr;

   int checks = 0;
   int errors = 0;

   logic [7:0] cap_byte [5];
   logic       cap_last [5];
   int         cap_n;
   int         cap_first;

`ifdef KYBER_COMPRESS_CHECK_EN
   localparam logic EXP_RANGE = 1'b1;
`else
   localparam logic EXP_RANGE = 1'b0;
`endif

   always #5 iClk = ~iClk;

   state_pack_cit__pack_polyvec__compress_serialize dut (
      .iClk           (iClk),
      .iRst           (iRst),
      .iPolyCoeffs_t0 (iPolyCoeffs_t0),
      .iPolyCoeffs_t1 (iPolyCoeffs_t1),
      .iPolyCoeffs_t2 (iPolyCoeffs_t2),
      .iPolyCoeffs_t3 (iPolyCoeffs_t3),
      .iValid         (iValid),
      .oReady         (oReady),
      .oByte          (oByte),
      .oByteValid     (oByteValid),
      .iByteReady     (iByteReady),
      .oLast          (oLast),
      .oRangeErr      (oRangeErr)
   );

   // Reference: true integer division, then the byte layout written out per byte.
   function automatic logic [39:0] model_pack(input logic [23:0] a, input logic [23:0] b,
                                              input logic [23:0] c, input logic [23:0] d);
      logic [9:0] u [4];
      logic [7:0] by [5];
      u[0] = 10'(a / 24'd3329);
      u[1] = 10'(b / 24'd3329);
      u[2] = 10'(c / 24'd3329);
      u[3] = 10'(d / 24'd3329);
      by[0] = u[0][7:0];
      by[1] = {u[1][5:0], u[0][9:8]};
      by[2] = {u[2][3:0], u[1][9:6]};
      by[3] = {u[3][1:0], u[2][9:4]};
      by[4] = u[3][9:2];
      return {by[4], by[3], by[2], by[1], by[0]};
   endfunction

   function automatic logic [23:0] coeff_t(input int c);
      return 24'((c << 10) + 1664);
   endfunction

   task automatic do_reset();
      iRst       = 1'b1;
      iValid     = 1'b0;
      iByteReady = 1'b1;
      repeat (2) @(negedge iClk);
      iRst = 1'b0;
   endtask

   // Waits (bounded) for oReady, presents one group for one cycle. Returns on
   // the falling edge right after the accepting rising edge.
   task automatic send_group(input logic [23:0] a, input logic [23:0] b,
                             input logic [23:0] c, input logic [23:0] d);
      int w = 0;
      while (!oReady && w < 20) begin
         @(negedge iClk);
         w++;
      end
      if (!oReady) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: oReady=%b after %0d cycles, want 1", oReady, w);
      end
      iPolyCoeffs_t0 = a;
      iPolyCoeffs_t1 = b;
      iPolyCoeffs_t2 = c;
      iPolyCoeffs_t3 = d;
      iValid         = 1'b1;
      @(negedge iClk);
      iValid = 1'b0;
   endtask

   // Records up to n transferred bytes within a cycle budget.
   task automatic collect(input int n, input int budget);
      cap_n     = 0;
      cap_first = -1;
      for (int cyc = 0; cyc < budget && cap_n < n; cyc++) begin
         @(negedge iClk);
         if (oByteValid && iByteReady) begin
            if (cap_n == 0) cap_first = cyc;
            cap_byte[cap_n] = oByte;
            cap_last[cap_n] = oLast;
            cap_n++;
         end
      end
      if (cap_n < n) begin
         checks++;
         errors++;
         $display("FAIL collect_timeout: got %0d bytes, want %0d", cap_n, n);
      end
   endtask

   task automatic test_reset();
      iPolyCoeffs_t0 = '0;
      iPolyCoeffs_t1 = '0;
      iPolyCoeffs_t2 = '0;
      iPolyCoeffs_t3 = '0;
      do_reset();
      checks++; if (oReady !== 1'b1)     begin errors++; $display("FAIL reset_ready: got %b want 1", oReady); end
      checks++; if (oByteValid !== 1'b0) begin errors++; $display("FAIL reset_bvalid: got %b want 0", oByteValid); end
      checks++; if (oLast !== 1'b0)      begin errors++; $display("FAIL reset_last: got %b want 0", oLast); end
      checks++; if (oByte !== 8'h00)     begin errors++; $display("FAIL reset_byte: got %02h want 00", oByte); end
      checks++; if (oRangeErr !== 1'b0)  begin errors++; $display("FAIL reset_rangeerr: got %b want 0", oRangeErr); end
   endtask

   task automatic test_zero();
      send_group(24'd1664, 24'd1664, 24'd1664, 24'd1664);
      checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL zero_ready_busy: got %b want 0", oReady); end
      collect(5, 20);
      // cycle index 1 of the collection window is cycle 3 counted from acceptance
      checks++; if (cap_first !== 1) begin errors++; $display("FAIL zero_latency: got %0d want 1", cap_first); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cap_byte[i] !== 8'h00 || cap_last[i] !== 1'b0) begin
            errors++;
            $display("FAIL zero_byte%0d: got %02h/last %b want 00/last 0", i, cap_byte[i], cap_last[i]);
         end
      end
   endtask

   task automatic test_vector();
      logic [7:0] exp [5] = '{8'h00, 8'hFE, 8'h4F, 8'h00, 8'h00};
      send_group(coeff_t(1665), coeff_t(3325), coeff_t(13), coeff_t(3328));
      collect(5, 20);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (cap_byte[i] !== exp[i]) begin
            errors++;
            $display("FAIL vector_byte%0d: got %02h want %02h", i, cap_byte[i], exp[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_tail [3] = '{8'h4F, 8'h00, 8'h00};
      send_group(coeff_t(1665), coeff_t(3325), coeff_t(13), coeff_t(3328));
      @(negedge iClk);
      @(negedge iClk);
      checks++;
      if (oByteValid !== 1'b1 || oByte !== 8'h00) begin
         errors++;
         $display("FAIL bp_byte0: got v%b %02h want v1 00", oByteValid, oByte);
      end
      @(negedge iClk);
      checks++;
      if (oByteValid !== 1'b1 || oByte !== 8'hFE) begin
         errors++;
         $display("FAIL bp_byte1: got v%b %02h want v1 FE", oByteValid, oByte);
      end
      iByteReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge iClk);
         checks++;
         if (oByteValid !== 1'b1 || oByte !== 8'hFE || oReady !== 1'b0 || oLast !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: got v%b %02h rdy%b last%b want v1 FE rdy0 last0",
                     k, oByteValid, oByte, oReady, oLast);
         end
      end
      iByteReady = 1'b1;
      collect(3, 10);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (cap_byte[i] !== exp_tail[i]) begin
            errors++;
            $display("FAIL bp_tail%0d: got %02h want %02h", i, cap_byte[i], exp_tail[i]);
         end
      end
   endtask

   // Streams ngroups random groups; oLast is expected only on byte 4 of
   // group index last_group (use -1 for none).
   task automatic run_groups(input int ngroups, input int last_group, input string tag);
      int          c [4];
      logic [23:0] tt [4];
      logic [39:0] exp_pack;
      logic        exp_last;
      for (int g = 0; g < ngroups; g++) begin
         for (int i = 0; i < 4; i++) begin
            c[i]  = int'($urandom_range(0, 3328));
            tt[i] = coeff_t(c[i]);
         end
         exp_pack = model_pack(tt[0], tt[1], tt[2], tt[3]);
         send_group(tt[0], tt[1], tt[2], tt[3]);
         collect(5, 20);
         for (int b = 0; b < 5; b++) begin
            exp_last = (g == last_group) && (b == 4);
            checks++;
            if (cap_byte[b] !== exp_pack[8*b +: 8] || cap_last[b] !== exp_last) begin
               errors++;
               $display("FAIL %s g%0d b%0d: got %02h/last %b want %02h/last %b",
                        tag, g, b, cap_byte[b], cap_last[b], exp_pack[8*b +: 8], exp_last);
            end
         end
      end
   endtask

   task automatic test_stream();
      do_reset();
      run_groups(128, 127, "stream");
      run_groups(1, -1, "stream_wrap");
   endtask

   task automatic test_reset_mid();
      do_reset();
      run_groups(5, -1, "pre_reset");
      send_group(coeff_t(1665), coeff_t(3325), coeff_t(13), coeff_t(3328));
      collect(3, 20);
      iRst = 1'b1;
      @(negedge iClk);
      checks++;
      if (oByteValid !== 1'b0 || oReady !== 1'b1 || oByte !== 8'h00 || oLast !== 1'b0) begin
         errors++;
         $display("FAIL midreset_state: got v%b rdy%b %02h last%b want v0 rdy1 00 last0",
                  oByteValid, oReady, oByte, oLast);
      end
      iRst = 1'b0;
      run_groups(128, 127, "after_reset");
   endtask

   task automatic test_range();
      do_reset();
      send_group(24'h800000, 24'd0, 24'd0, 24'd0);
      checks++;
      if (oRangeErr !== EXP_RANGE) begin
         errors++;
         $display("FAIL range_set: got %b want %b", oRangeErr, EXP_RANGE);
      end
      collect(5, 20);
      send_group(coeff_t(1), coeff_t(2), coeff_t(3), coeff_t(4));
      collect(5, 20);
      checks++;
      if (oRangeErr !== EXP_RANGE) begin
         errors++;
         $display("FAIL range_sticky: got %b want %b", oRangeErr, EXP_RANGE);
      end
      do_reset();
      checks++;
      if (oRangeErr !== 1'b0) begin
         errors++;
         $display("FAIL range_clear: got %b want 0", oRangeErr);
      end
   endtask

   initial begin
      iRst       = 1'b1;
      iValid     = 1'b0;
      iByteReady = 1'b1;
      @(negedge iClk);
      test_reset();
      test_zero();
      test_vector();
      test_backpressure();
      test_stream();
      test_reset_mid();
      test_range();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
